p_flash_writer: RTL and testbench
=================================

Name: p_flash_writer

Overview:
- Write-side counterpart of the PROG CPLD read path. It issues AMD-style command sequences (program word, sector erase, chip erase, reset) to the three 55LV100S P-ROM flash chips.
- It shares the same P_ADDR/P_nCE/P_nOE bus and the same chip-select split (address bits 27:26).
- It is driven by a command handshake from the MCU bridge. It reports completion through a status word.
- It is active only while the 68K read path is parked (cartridge programming mode).

Parameters:
- WE_CYC, 3, P_nWE low-pulse width in clocks (1..15)
- SETUP_CYC, 1, address/data setup before P_nWE falls, in clocks (1..15)
- RD_CYC, 4, P_nOE low time before DQ is sampled during polling, in clocks (1..15)
- POLL_MAX, 24'hFFFFFF, maximum poll reads before timeout

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  block idle and accepting a command
- CMD_OP  in  2  operation: 0 = program word, 1 = sector erase, 2 = chip erase, 3 = reset (F0)
- CMD_ADDR  in  28  word address; [27:26] selects the chip, [25:0] is the in-chip address
- CMD_DATA  in  16  program data
- STAT_DONE  out  1  one-cycle pulse when a command finishes
- STAT_ERR  out  1  sticky error flag; cleared when the next command is accepted
- P_ADDR  out  26  flash address
- P_nCE  out  3  chip enables, one-hot low
- P_nOE  out  1  flash output enable
- P_nWE  out  1  flash write enable
- P_DQ_O  out  16  flash data out
- P_DQ_OE  out  1  flash data driver enable
- P_DQ_I  in  16  flash data in

Behaviour:
- Interface: one clock CLK; reset RESET is synchronous and active-high.
- Reset values:
  - P_nCE = 3'b111; P_nOE = 1; P_nWE = 1; P_DQ_OE = 0.
  - P_ADDR = 0; P_DQ_O = 0.
  - CMD_READY = 1; STAT_DONE = 0; STAT_ERR = 0; state = IDLE.
- RESET mid-operation: abort at the next edge. All strobes return high immediately, with no completion of the current bus cycle.
- Handshake:
  - A command is accepted on a CLK edge where CMD_VALID && CMD_READY.
  - CMD_OP, CMD_ADDR and CMD_DATA are latched at that edge.
  - CMD_READY drops on the following cycle and stays low until STAT_DONE is pulsed.
- Chip select: latched CMD_ADDR[27:26] maps 00→110, 01→101, 10→011.
  - The value 11 sets STAT_ERR and pulses STAT_DONE on the cycle after acceptance. No bus cycles are issued.
- Sequence ROM (address/data pairs, word mode):
  - program: 555/AA, 2AA/55, 555/A0, ADDR/DATA
  - sector erase: 555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, ADDR/0030
  - chip erase: same as sector erase, but the last step is 555/0010
  - reset: ADDR/00F0, with no polling
- Write states:
  - IDLE → SETUP: drive P_ADDR, P_DQ_O and P_DQ_OE = 1, and assert P_nCE for SETUP_CYC clocks.
  - SETUP → WE_LO: hold P_nWE = 0 for WE_CYC clocks.
  - WE_LO → WE_HI: raise P_nWE for 1 clock, holding address and data.
  - WE_HI: if more steps remain, go to SETUP with step+1; otherwise go to POLL (or DONE for reset).
  - P_nCE stays asserted across the whole sequence.
- POLL state:
  - P_DQ_OE = 0; P_nOE = 0 for RD_CYC clocks; P_ADDR = target address; sample P_DQ_I on the last cycle.
  - Expected DQ7 = CMD_DATA[7] for program, 1 for erase.
  - If DQ7 matches → DONE.
  - Else if DQ5 = 1 → one extra poll read: match → DONE, mismatch → ERR.
  - Else increment the poll counter. At POLL_MAX → ERR; otherwise re-poll after P_nOE is high for 1 clock.
- DONE / ERR:
  - Deassert all strobes and pulse STAT_DONE for 1 clock.
  - ERR additionally sets STAT_ERR.
  - Then go to IDLE (CMD_READY = 1 the next cycle).
- Bus safety: P_nOE and P_nWE are never low in the same cycle. P_DQ_OE is 0 whenever P_nOE = 0.
- Counters saturate and never wrap; the 24-bit poll counter is cleared on accept.
- CMD_VALID while busy is ignored and is not queued.

Optional Feature:
- Macro: P_VERIFY_EN.
- With the macro: after a program DONE-match, one extra read of the target address is made. Data ≠ CMD_DATA → ERR. Erase success additionally requires the read word to be 16'hFFFF.
- Without the macro: DQ7 polling alone decides success.

Decomposition:
- Shared package p_flash_pkg holds:
  - op codes;
  - unlock addresses 0x555 and 0x2AA;
  - command bytes AA, 55, A0, 80, 30, 10, F0;
  - the state enum;
  - the CSEL→P_nCE mapping function shared with the read path.
- One sub-module, p_flash_seq_rom: combinational (op, step) → {addr_sel, data, last}.

Test Plan:
- Program: op 0, ADDR 28'h0000123, DATA 16'h5A3C; the model returns DQ7 inverted for 5 reads, then true. Required: 4 write pulses (555/AA, 2AA/55, 555/A0, 123/5A3C), P_nCE = 110 throughout, 6 poll reads, STAT_DONE once, STAT_ERR = 0.
- Sector erase: op 1, ADDR 28'h4010000. Required: P_nCE = 101, 6 writes ending 0010000/0030, poll until DQ7 = 1, then DONE.
- Chip select 11: op 0, ADDR 28'hC000000. Required: no P_nWE or P_nOE activity, STAT_DONE and STAT_ERR on the cycle after accept.
- DQ5 timeout: the model holds DQ7 wrong with DQ5 = 1. Required: exactly 2 poll reads, then STAT_ERR = 1; the next accepted command clears it.
- RESET asserted during WE_LO of step 2. Required: P_nWE, P_nCE and P_nOE all high and CMD_READY = 1 on the next edge; a new command then runs normally.
- Protocol monitor across all tests: never P_nOE = 0 with P_nWE = 0 or with P_DQ_OE = 1; CMD_VALID pulses while busy are ignored.

Source files
------------

// File: rtl/p_flash_pkg.sv
// Shared types and constants for the P-ROM flash write path (AMD-style command set).
package p_flash_pkg;

    localparam int unsigned ADDR_W     = 26;
    localparam int unsigned CMD_ADDR_W = 28;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned CE_W       = 3;
    localparam int unsigned OP_W       = 2;
    localparam int unsigned STEP_W     = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned POLL_W     = 24;

    typedef enum logic [OP_W-1:0] {
        OP_PROG       = 2'd0,
        OP_SECT_ERASE = 2'd1,
        OP_CHIP_ERASE = 2'd2,
        OP_RESET      = 2'd3
    } op_e;

    localparam logic [ADDR_W-1:0] UNLOCK_ADDR1 = 26'h555;
    localparam logic [ADDR_W-1:0] UNLOCK_ADDR2 = 26'h2AA;

    localparam logic [DATA_W-1:0] CMD_AA = 16'h00AA;
    localparam logic [DATA_W-1:0] CMD_55 = 16'h0055;
    localparam logic [DATA_W-1:0] CMD_A0 = 16'h00A0;
    localparam logic [DATA_W-1:0] CMD_80 = 16'h0080;
    localparam logic [DATA_W-1:0] CMD_30 = 16'h0030;
    localparam logic [DATA_W-1:0] CMD_10 = 16'h0010;
    localparam logic [DATA_W-1:0] CMD_F0 = 16'h00F0;

    typedef enum logic [1:0] {
        ASEL_UNLOCK1 = 2'd0,
        ASEL_UNLOCK2 = 2'd1,
        ASEL_TARGET  = 2'd2
    } addr_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WE_LO    = 3'd2,
        ST_WE_HI    = 3'd3,
        ST_POLL     = 3'd4,
        ST_POLL_GAP = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } state_e;

    // One bus write of a command sequence; use_cmd_data substitutes the program word.
    typedef struct packed {
        addr_sel_e         addr_sel;
        logic              use_cmd_data;
        logic [DATA_W-1:0] data;
        logic              last;
    } seq_step_t;

    function automatic logic [CE_W-1:0] csel_to_nce(input logic [1:0] csel);
        case (csel)
            2'b00:   return 3'b110;
            2'b01:   return 3'b101;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/p_flash_if.sv
// Command handshake, status and P-ROM flash bus bundle for the flash writer.
interface p_flash_if;
    import p_flash_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [OP_W-1:0]       cmd_op;
    logic [CMD_ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0]     cmd_data;
    logic                  stat_done;
    logic                  stat_err;
    logic [ADDR_W-1:0]     p_addr;
    logic [CE_W-1:0]       p_nce;
    logic                  p_noe;
    logic                  p_nwe;
    logic [DATA_W-1:0]     p_dq_o;
    logic                  p_dq_oe;
    logic [DATA_W-1:0]     p_dq_i;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, p_dq_i,
        input  cmd_ready, stat_done, stat_err, p_addr, p_nce, p_noe, p_nwe, p_dq_o, p_dq_oe
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, p_dq_i,
        output cmd_ready, stat_done, stat_err, p_addr, p_nce, p_noe, p_nwe, p_dq_o, p_dq_oe
    );

endinterface

// File: rtl/p_flash_seq_rom.sv
// Command sequence table: (op, step) -> address select, data word, last-step flag.
module p_flash_seq_rom
    import p_flash_pkg::*;
(
    input  op_e               op,
    input  logic [STEP_W-1:0] step,
    output seq_step_t         entry
);

    always_comb begin
        entry = '{addr_sel: ASEL_TARGET, use_cmd_data: 1'b0, data: CMD_F0, last: 1'b1};
        unique case (op)
            OP_PROG: begin
                case (step)
                    3'd0:    entry = '{ASEL_UNLOCK1, 1'b0, CMD_AA, 1'b0};
                    3'd1:    entry = '{ASEL_UNLOCK2, 1'b0, CMD_55, 1'b0};
                    3'd2:    entry = '{ASEL_UNLOCK1, 1'b0, CMD_A0, 1'b0};
                    default: entry = '{ASEL_TARGET,  1'b1, 16'h0000, 1'b1};
                endcase
            end
            OP_SECT_ERASE, OP_CHIP_ERASE: begin
                case (step)
                    3'd0: entry = '{ASEL_UNLOCK1, 1'b0, CMD_AA, 1'b0};
                    3'd1: entry = '{ASEL_UNLOCK2, 1'b0, CMD_55, 1'b0};
                    3'd2: entry = '{ASEL_UNLOCK1, 1'b0, CMD_80, 1'b0};
                    3'd3: entry = '{ASEL_UNLOCK1, 1'b0, CMD_AA, 1'b0};
                    3'd4: entry = '{ASEL_UNLOCK2, 1'b0, CMD_55, 1'b0};
                    default: begin
                        if (op == OP_SECT_ERASE) entry = '{ASEL_TARGET,  1'b0, CMD_30, 1'b1};
                        else                     entry = '{ASEL_UNLOCK1, 1'b0, CMD_10, 1'b1};
                    end
                endcase
            end
            OP_RESET: entry = '{ASEL_TARGET, 1'b0, CMD_F0, 1'b1};
        endcase
    end

endmodule

// File: rtl/p_flash_writer.sv
// P-ROM flash writer: issues program/erase/reset command sequences and DQ7-polls for completion.
// Define P_VERIFY_EN to add a full-word read-back check after polling succeeds.
module p_flash_writer
    import p_flash_pkg::*;
#(
    parameter int unsigned       WE_CYC    = 3,
    parameter int unsigned       SETUP_CYC = 1,
    parameter int unsigned       RD_CYC    = 4,
    parameter logic [POLL_W-1:0] POLL_MAX  = 24'hFFFFFF
) (
    input logic       clk,
    input logic       reset,
    p_flash_if.slave  bus
);

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  WE_LAST    = CNT_W'(WE_CYC - 1);
    localparam logic [CNT_W-1:0]  RD_LAST    = CNT_W'(RD_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_MAX - POLL_W'(1);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [CMD_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [POLL_W-1:0]     poll_q, poll_d;
    logic                  retry_q, retry_d;
    logic                  last_q;
    logic                  accept, dq7_ok, exp_dq7;
    seq_step_t             nxt_step;

    logic [CE_W-1:0]   nce_d;
    logic [ADDR_W-1:0] p_addr_d;
    logic [DATA_W-1:0] dq_o_d;
    logic              dq_oe_d, nwe_d, noe_d, ready_d, done_d, err_d;
    logic              bus_active, writing;

`ifdef P_VERIFY_EN
    logic              vfy_q, vfy_d;
    logic [DATA_W-1:0] exp_word;
    assign exp_word = (op_q == OP_PROG) ? data_q : 16'hFFFF;
`endif

    assign exp_dq7 = (op_q == OP_PROG) ? data_q[7] : 1'b1;

    // Looked up with the next step so the driven address/data line up with the state it enters.
    p_flash_seq_rom u_rom (
        .op    (op_d),
        .step  (step_d),
        .entry (nxt_step)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        step_d  = step_q;
        poll_d  = poll_q;
        retry_d = retry_q;
        accept  = 1'b0;
        dq7_ok  = 1'b0;
`ifdef P_VERIFY_EN
        vfy_d   = vfy_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    op_d    = op_e'(bus.cmd_op);
                    addr_d  = bus.cmd_addr;
                    data_d  = bus.cmd_data;
                    step_d  = '0;
                    poll_d  = '0;
                    retry_d = 1'b0;
`ifdef P_VERIFY_EN
                    vfy_d   = 1'b0;
`endif
                    state_d = (bus.cmd_addr[27:26] == 2'b11) ? ST_ERR : ST_SETUP;
                end
            end
            ST_SETUP: if (cnt_q == SETUP_LAST) state_d = ST_WE_LO;
            ST_WE_LO: if (cnt_q == WE_LAST)    state_d = ST_WE_HI;
            ST_WE_HI: begin
                if (!last_q) begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = ST_SETUP;
                end else begin
                    state_d = (op_q == OP_RESET) ? ST_DONE : ST_POLL;
                end
            end
            ST_POLL: begin
                if (cnt_q == RD_LAST) begin
                    dq7_ok = (bus.p_dq_i[7] == exp_dq7);
`ifdef P_VERIFY_EN
                    if (vfy_q) state_d = (bus.p_dq_i == exp_word) ? ST_DONE : ST_ERR;
                    else if (dq7_ok) begin
                        vfy_d   = 1'b1;
                        state_d = ST_POLL_GAP;
                    end
`else
                    if (dq7_ok) state_d = ST_DONE;
`endif
                    else if (retry_q) state_d = ST_ERR;
                    else if (bus.p_dq_i[5]) begin
                        retry_d = 1'b1;
                        state_d = ST_POLL_GAP;
                    end else if (poll_q >= POLL_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        poll_d  = (poll_q == '1) ? poll_q : poll_q + POLL_W'(1);
                        state_d = ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: state_d = ST_POLL;
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1));
    end

    // Bus and status values for the state being entered; registered below.
    always_comb begin
        bus_active = state_d inside {ST_SETUP, ST_WE_LO, ST_WE_HI, ST_POLL, ST_POLL_GAP};
        writing    = state_d inside {ST_SETUP, ST_WE_LO, ST_WE_HI};
        nce_d      = bus_active ? csel_to_nce(addr_d[27:26]) : 3'b111;
        p_addr_d   = bus.p_addr;
        dq_o_d     = bus.p_dq_o;
        if (writing) begin
            case (nxt_step.addr_sel)
                ASEL_UNLOCK1: p_addr_d = UNLOCK_ADDR1;
                ASEL_UNLOCK2: p_addr_d = UNLOCK_ADDR2;
                default:      p_addr_d = addr_d[ADDR_W-1:0];
            endcase
            dq_o_d = nxt_step.use_cmd_data ? data_d : nxt_step.data;
        end else if (bus_active) begin
            p_addr_d = addr_d[ADDR_W-1:0];
        end
        dq_oe_d = writing;
        nwe_d   = (state_d != ST_WE_LO);
        noe_d   = (state_d != ST_POLL);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE) || (state_d == ST_ERR);
        err_d   = accept ? 1'b0 : bus.stat_err;
        if (state_d == ST_ERR) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_PROG;
            addr_q        <= '0;
            data_q        <= '0;
            step_q        <= '0;
            cnt_q         <= '0;
            poll_q        <= '0;
            retry_q       <= 1'b0;
            last_q        <= 1'b0;
            bus.p_nce     <= 3'b111;
            bus.p_noe     <= 1'b1;
            bus.p_nwe     <= 1'b1;
            bus.p_dq_oe   <= 1'b0;
            bus.p_addr    <= '0;
            bus.p_dq_o    <= '0;
            bus.cmd_ready <= 1'b1;
            bus.stat_done <= 1'b0;
            bus.stat_err  <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            poll_q        <= poll_d;
            retry_q       <= retry_d;
            last_q        <= nxt_step.last;
            bus.p_nce     <= nce_d;
            bus.p_noe     <= noe_d;
            bus.p_nwe     <= nwe_d;
            bus.p_dq_oe   <= dq_oe_d;
            bus.p_addr    <= p_addr_d;
            bus.p_dq_o    <= dq_o_d;
            bus.cmd_ready <= ready_d;
            bus.stat_done <= done_d;
            bus.stat_err  <= err_d;
        end
    end

`ifdef P_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset) vfy_q <= 1'b0;
        else       vfy_q <= vfy_d;
    end
`endif

endmodule

// File: tb/tb_p_flash_writer.sv
// Directed self-checking bench for p_flash_writer with a DQ7-polling flash model and bus monitor.
module tb_p_flash_writer;

    logic clk;
    logic reset;
    p_flash_if bus ();

    p_flash_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Flash model: the first bad_reads poll reads of a command return bad_word.
    logic [15:0] good_word = 16'h0000;
    logic [15:0] bad_word  = 16'h0000;
    int          bad_reads = 0;
    int          rd_base   = 0;

    // Monitor state (written only by the monitor process).
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    int          done_cnt = 0;
    int          viol_cnt = 0;
    logic [25:0] wr_addr [64];
    logic [15:0] wr_data [64];
    logic [2:0]  wr_nce  [64];
    logic [2:0]  rd_nce_last = 3'b111;
    logic        prev_nwe = 1'b1;
    logic        prev_noe = 1'b1;

    assign bus.p_dq_i = ((rd_cnt - rd_base) <= bad_reads) ? bad_word : good_word;

    always @(negedge clk) begin
        if (prev_nwe && (bus.p_nwe === 1'b0)) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = bus.p_addr;
                wr_data[wr_cnt] = bus.p_dq_o;
                wr_nce[wr_cnt]  = bus.p_nce;
            end
            wr_cnt++;
        end
        if (prev_noe && (bus.p_noe === 1'b0)) begin
            rd_nce_last = bus.p_nce;
            rd_cnt++;
        end
        if (bus.stat_done === 1'b1) done_cnt++;
        if ((bus.p_noe === 1'b0) && ((bus.p_nwe === 1'b0) || (bus.p_dq_oe === 1'b1))) viol_cnt++;
        prev_nwe = (bus.p_nwe !== 1'b0);
        prev_noe = (bus.p_noe !== 1'b0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] op, input logic [27:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.stat_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.p_nce !== 3'b111) begin n_bad++; $display("FAIL reset_nce: got %b want 111", bus.p_nce); end
        n_cmp++; if (bus.p_noe !== 1'b1) begin n_bad++; $display("FAIL reset_noe: got %b want 1", bus.p_noe); end
        n_cmp++; if (bus.p_nwe !== 1'b1) begin n_bad++; $display("FAIL reset_nwe: got %b want 1", bus.p_nwe); end
        n_cmp++; if (bus.p_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dq_oe: got %b want 0", bus.p_dq_oe); end
        n_cmp++; if (bus.p_addr !== 26'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.p_addr); end
        n_cmp++; if (bus.p_dq_o !== 16'h0) begin n_bad++; $display("FAIL reset_dq_o: got %h want 0", bus.p_dq_o); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.stat_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.stat_done); end
        n_cmp++; if (bus.stat_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.stat_err); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_program();
        int wb, db, vb;
        bit seen;
        logic [25:0] ea [4];
        logic [15:0] ed [4];
        ea = '{26'h555, 26'h2AA, 26'h555, 26'h123};
        ed = '{16'h00AA, 16'h0055, 16'h00A0, 16'h5A3C};
        good_word = 16'h5A3C; bad_word = 16'h0080; bad_reads = 5; rd_base = rd_cnt;
        wb = wr_cnt; db = done_cnt; vb = viol_cnt;
        issue(2'd0, 28'h0000123, 16'h5A3C);
        repeat (4) @(negedge clk);
        // Requests while busy must be dropped, not queued.
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_addr = 28'hC000000;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL prog_busy_ready: got %b want 0", bus.cmd_ready); end
        bus.cmd_valid = 1'b0;
        wait_done(500, seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL prog_done_timeout: got %b want 1", seen); end
        n_cmp++; if (bus.stat_err !== 1'b0) begin n_bad++; $display("FAIL prog_err: got %b want 0", bus.stat_err); end
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL prog_ready_after: got %b want 1", bus.cmd_ready); end
        repeat (10) @(negedge clk);
        n_cmp++; if (wr_cnt - wb !== 4) begin n_bad++; $display("FAIL prog_wr_count: got %0d want 4", wr_cnt - wb); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({wr_addr[wb+i], wr_data[wb+i], wr_nce[wb+i]} !== {ea[i], ed[i], 3'b110}) begin
                n_bad++;
                $display("FAIL prog_wr%0d: got %h/%h nce %b want %h/%h nce 110", i, wr_addr[wb+i], wr_data[wb+i], wr_nce[wb+i], ea[i], ed[i]);
            end
        end
        n_cmp++; if (rd_cnt - rd_base !== 6) begin n_bad++; $display("FAIL prog_rd_count: got %0d want 6", rd_cnt - rd_base); end
        n_cmp++; if (rd_nce_last !== 3'b110) begin n_bad++; $display("FAIL prog_rd_nce: got %b want 110", rd_nce_last); end
        n_cmp++; if (done_cnt - db !== 1) begin n_bad++; $display("FAIL prog_done_count: got %0d want 1", done_cnt - db); end
        n_cmp++; if (viol_cnt !== vb) begin n_bad++; $display("FAIL prog_bus_safety: got %0d want %0d", viol_cnt, vb); end
    endtask

    task automatic test_sector_erase();
        int wb, vb;
        bit seen;
        logic [25:0] ea [6];
        logic [15:0] ed [6];
        ea = '{26'h555, 26'h2AA, 26'h555, 26'h555, 26'h2AA, 26'h0010000};
        ed = '{16'h00AA, 16'h0055, 16'h0080, 16'h00AA, 16'h0055, 16'h0030};
        good_word = 16'hFFFF; bad_word = 16'h0000; bad_reads = 3; rd_base = rd_cnt;
        wb = wr_cnt; vb = viol_cnt;
        issue(2'd1, 28'h4010000, 16'h0000);
        wait_done(800, seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL se_done_timeout: got %b want 1", seen); end
        n_cmp++; if (bus.stat_err !== 1'b0) begin n_bad++; $display("FAIL se_err: got %b want 0", bus.stat_err); end
        repeat (5) @(negedge clk);
        n_cmp++; if (wr_cnt - wb !== 6) begin n_bad++; $display("FAIL se_wr_count: got %0d want 6", wr_cnt - wb); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({wr_addr[wb+i], wr_data[wb+i], wr_nce[wb+i]} !== {ea[i], ed[i], 3'b101}) begin
                n_bad++;
                $display("FAIL se_wr%0d: got %h/%h nce %b want %h/%h nce 101", i, wr_addr[wb+i], wr_data[wb+i], wr_nce[wb+i], ea[i], ed[i]);
            end
        end
        n_cmp++; if (rd_cnt - rd_base !== 4) begin n_bad++; $display("FAIL se_rd_count: got %0d want 4", rd_cnt - rd_base); end
        n_cmp++; if (viol_cnt !== vb) begin n_bad++; $display("FAIL se_bus_safety: got %0d want %0d", viol_cnt, vb); end
    endtask

    task automatic test_chip_sel();
        int wb, rb;
        wb = wr_cnt; rb = rd_cnt;
        issue(2'd0, 28'hC000000, 16'h1111);
        @(negedge clk);
        n_cmp++; if (bus.stat_done !== 1'b1) begin n_bad++; $display("FAIL cs11_done: got %b want 1", bus.stat_done); end
        n_cmp++; if (bus.stat_err !== 1'b1) begin n_bad++; $display("FAIL cs11_err: got %b want 1", bus.stat_err); end
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL cs11_ready_low: got %b want 0", bus.cmd_ready); end
        @(negedge clk);
        n_cmp++; if ({bus.cmd_ready, bus.stat_done} !== 2'b10) begin n_bad++; $display("FAIL cs11_back_idle: got %b want 10", {bus.cmd_ready, bus.stat_done}); end
        repeat (5) @(negedge clk);
        n_cmp++; if ({wr_cnt - wb, rd_cnt - rb} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL cs11_bus_activity: got wr %0d rd %0d want 0 0", wr_cnt - wb, rd_cnt - rb); end
    endtask

    task automatic test_dq5_timeout();
        int wb;
        bit seen;
        good_word = 16'h0080; bad_word = 16'h0020; bad_reads = 1000; rd_base = rd_cnt;
        issue(2'd0, 28'h0000010, 16'h0080);
        wait_done(500, seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL dq5_done_timeout: got %b want 1", seen); end
        n_cmp++; if (bus.stat_err !== 1'b1) begin n_bad++; $display("FAIL dq5_err: got %b want 1", bus.stat_err); end
        repeat (5) @(negedge clk);
        n_cmp++; if (rd_cnt - rd_base !== 2) begin n_bad++; $display("FAIL dq5_rd_count: got %0d want 2", rd_cnt - rd_base); end
        n_cmp++; if (bus.stat_err !== 1'b1) begin n_bad++; $display("FAIL dq5_err_sticky: got %b want 1", bus.stat_err); end
        // Reset command (F0) clears the sticky error on acceptance and never polls.
        rd_base = rd_cnt; wb = wr_cnt;
        issue(2'd3, 28'h0000000, 16'h0000);
        @(negedge clk);
        n_cmp++; if (bus.stat_err !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_accept: got %b want 0", bus.stat_err); end
        wait_done(200, seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_op_done_timeout: got %b want 1", seen); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_cnt - wb, wr_addr[wb], wr_data[wb], wr_nce[wb]} !== {32'd1, 26'h0, 16'h00F0, 3'b110}) begin
            n_bad++;
            $display("FAIL rst_op_write: got n %0d %h/%h nce %b want n 1 0/00f0 nce 110", wr_cnt - wb, wr_addr[wb], wr_data[wb], wr_nce[wb]);
        end
        n_cmp++; if (rd_cnt - rd_base !== 0) begin n_bad++; $display("FAIL rst_op_no_poll: got %0d want 0", rd_cnt - rd_base); end
        n_cmp++; if (bus.stat_err !== 1'b0) begin n_bad++; $display("FAIL rst_op_err: got %b want 0", bus.stat_err); end
    endtask

    task automatic test_reset_mid();
        int wb;
        bit reached, seen;
        wb = wr_cnt;
        issue(2'd1, 28'h8000000, 16'h0000);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt - wb >= 3) reached = 1'b1;
        end
        n_cmp++; if (reached !== 1'b1) begin n_bad++; $display("FAIL rm_reach_step2: got %b want 1", reached); end
        n_cmp++; if (bus.p_nwe !== 1'b0) begin n_bad++; $display("FAIL rm_in_we_lo: got %b want 0", bus.p_nwe); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.p_nwe, bus.p_nce, bus.p_noe, bus.p_dq_oe, bus.cmd_ready} !== 7'b1_111_1_0_1) begin
            n_bad++;
            $display("FAIL rm_abort: got nwe %b nce %b noe %b oe %b rdy %b want 1 111 1 0 1", bus.p_nwe, bus.p_nce, bus.p_noe, bus.p_dq_oe, bus.cmd_ready);
        end
        n_cmp++; if (wr_nce[wb] !== 3'b011) begin n_bad++; $display("FAIL rm_nce_chip2: got %b want 011", wr_nce[wb]); end
        reset = 1'b0;
        good_word = 16'h1234; bad_word = 16'h0080; bad_reads = 0; rd_base = rd_cnt;
        wb = wr_cnt;
        issue(2'd0, 28'h8000040, 16'h1234);
        wait_done(500, seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rm_rerun_timeout: got %b want 1", seen); end
        n_cmp++; if (bus.stat_err !== 1'b0) begin n_bad++; $display("FAIL rm_rerun_err: got %b want 0", bus.stat_err); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_cnt - wb, wr_addr[wb+3], wr_data[wb+3], wr_nce[wb+3]} !== {32'd4, 26'h40, 16'h1234, 3'b011}) begin
            n_bad++;
            $display("FAIL rm_rerun_write: got n %0d %h/%h nce %b want n 4 40/1234 nce 011", wr_cnt - wb, wr_addr[wb+3], wr_data[wb+3], wr_nce[wb+3]);
        end
        n_cmp++; if (rd_cnt - rd_base !== 1) begin n_bad++; $display("FAIL rm_rerun_rd: got %0d want 1", rd_cnt - rd_base); end
        n_cmp++; if (viol_cnt !== 0) begin n_bad++; $display("FAIL bus_safety_total: got %0d want 0", viol_cnt); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = 28'h0;
        bus.cmd_data  = 16'h0;
        test_reset();
        test_program();
        test_sector_erase();
        test_chip_sel();
        test_dq5_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
